arp_cache_lookup: RTL and testbench
===================================

// Module: arp_cache_lookup
// PURPOSE
//  Resolves the next-hop IPv4 address from the LPM stage to a destination MAC. Sits between LPM
//  and the MAC-rewrite/forward stage, driving that stage's dest_mac/arp_hit/oq_reg inputs.
//  Holds a software-written ARP table, searched sequentially. One lookup in flight at a time.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  width of counter / clear-register ports
//  ARP_DEPTH           32  ARP table entries (power of 2, 2..256)
//  ARP_IDX_W           5   log2(ARP_DEPTH)
// PORTS
//  AXI_ACLK        in   1      sole clock
//  AXI_RESET       in   1      asynchronous, active-high reset
//  lookup_req      in   1      request valid; next_hop_ip/oq_in are stable while high
//  lookup_ready    out  1      block can accept a request (IDLE)
//  next_hop_ip     in   32     IPv4 address to resolve
//  oq_in           in   8      one-hot output port chosen by LPM
//  lookup_valid    out  1      result valid, held until lookup_ack
//  lookup_ack      in   1      consumer has taken the result
//  arp_hit         out  1      match found
//  dest_mac        out  48     MAC of the matching entry; 0 on miss
//  oq_reg          out  8      oq_in registered at acceptance
//  tbl_wr_en       in   1      write table entry
//  tbl_wr_addr     in   ARP_IDX_W  entry index
//  tbl_wr_ip       in   32     entry IP
//  tbl_wr_mac      in   48     entry MAC
//  tbl_wr_vld      in   1      entry valid bit (0 = delete)
//  tbl_rd_addr     in   ARP_IDX_W  software read index
//  tbl_rd_ip       out  32     combinational read of entry IP
//  tbl_rd_mac      out  48     combinational read of entry MAC
//  tbl_rd_vld      out  1      combinational read of entry valid bit
//  reset           in   C_S_AXI_DATA_WIDTH  counter clear; value 32'd1 clears
//  arp_lookup_count out C_S_AXI_DATA_WIDTH  accepted lookups
//  arp_hit_count   out  C_S_AXI_DATA_WIDTH  lookups that hit
// BEHAVIOUR
//  Reset: state=IDLE, lookup_ready=1, lookup_valid=0, arp_hit=0, dest_mac=0, oq_reg=0,
//   counters=0, all table valid bits=0. IP/MAC contents need no reset.
//  FSM IDLE -> SEARCH -> DONE -> IDLE.
//   IDLE: lookup_ready=1. When lookup_req=1, latch next_hop_ip and oq_in (oq_reg), set idx=0,
//    increment arp_lookup_count, go to SEARCH.
//   SEARCH: each cycle compares entry[idx]; match = vld && ip==latched ip.
//    On match: arp_hit=1, dest_mac=entry MAC, arp_hit_count+1, go to DONE.
//    On no match at idx==ARP_DEPTH-1: arp_hit=0, dest_mac=0, go to DONE. Otherwise idx+1.
//    The lowest matching index wins. Worst-case latency from accept to lookup_valid is ARP_DEPTH+1.
//   DONE: lookup_valid=1 and the outputs are held stable. When lookup_ack=1, return to IDLE.
//    lookup_ready rises the cycle after the ack, so there is one idle cycle between lookups.
//  Table write: synchronous, one cycle. A write to entry idx in the same cycle it is compared
//   compares the old contents. Entries already passed are not re-scanned.
//  Simultaneous counter increment and clear (reset==1): the clear wins and the counter becomes 0.
//   Counters wrap at 2^C_S_AXI_DATA_WIDTH. The clear does not affect the FSM or the table.
//  AXI_RESET mid-search: the lookup is abandoned and the table is invalidated. The upstream stage
//   must re-issue the lookup.
//  lookup_ack outside DONE is ignored. lookup_req outside IDLE is ignored (not queued).
//  next_hop_ip == 0 is looked up like any other value. Next-hop substitution is done upstream.
// STRUCTURE
//  Shared header arp_defs.vh: ARP_DEPTH default, entry field widths (IP 32, MAC 48), state encodings
//   (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2), counter-clear magic value 32'd1.
//  Sub-module arp_table_regs: register file with one write port, a scan read port (idx) and a
//   software read port (tbl_rd_addr), with per-entry valid bits cleared on AXI_RESET.
//  Top level holds the FSM, idx counter, result registers and counters.
// TESTING
//  1 Write entry 3 = {10.0.0.2, 00:11:22:33:44:55, vld}; lookup 10.0.0.2, oq_in=8'h04
//    -> lookup_valid after 5 cycles, arp_hit=1, dest_mac=48'h001122334455, oq_reg=8'h04.
//  2 Empty table, lookup 10.0.0.9 -> lookup_valid after 33 cycles, arp_hit=0, dest_mac=0,
//    arp_lookup_count=1, arp_hit_count=0.
//  3 Entries 5 and 9 both hold 10.0.0.7 (MACs ..05, ..09) -> hit returns MAC ..05 at latency 7.
//  4 Hold lookup_ack=0 for 10 cycles in DONE -> outputs stable; write entry 5 meanwhile,
//    result unchanged. After ack, lookup_ready=1 the next cycle.
//  5 Write entry 0 vld=0 while scanning idx 20 -> no effect. Delete entry 3 then re-look-up
//    10.0.0.2 -> miss.
//  6 Assert reset=1 in the same cycle a hit occurs -> both counters read 0. Assert AXI_RESET
//    mid-SEARCH -> IDLE, lookup_valid=0, tbl_rd_vld=0 for all indices.

Source files
------------

// File: rtl/arp_cache_lookup_pkg.sv
// Shared types and constants for the ARP cache lookup block.
package arp_cache_lookup_pkg;
  localparam int IP_W  = 32;
  localparam int MAC_W = 48;
  localparam int OQ_W  = 8;
  localparam logic [31:0] CNT_CLR = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } arp_state_e;

  typedef struct packed {
    logic             vld;
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
  } arp_entry_t;
endpackage

// File: rtl/arp_cache_lookup_if.sv
// Lookup request/response handshake between LPM, the ARP block and the rewrite stage.
interface arp_cache_lookup_if;
  import arp_cache_lookup_pkg::*;
  logic             lookup_req;
  logic             lookup_ready;
  logic [IP_W-1:0]  next_hop_ip;
  logic [OQ_W-1:0]  oq_in;
  logic             lookup_valid;
  logic             lookup_ack;
  logic             arp_hit;
  logic [MAC_W-1:0] dest_mac;
  logic [OQ_W-1:0]  oq_reg;

  modport master (output lookup_req, next_hop_ip, oq_in, lookup_ack,
                  input  lookup_ready, lookup_valid, arp_hit, dest_mac, oq_reg);
  modport slave  (input  lookup_req, next_hop_ip, oq_in, lookup_ack,
                  output lookup_ready, lookup_valid, arp_hit, dest_mac, oq_reg);
endinterface

// File: rtl/arp_cache_lookup_table_regs.sv
// ARP table register file: one write port, a scan read port and a software read port.
module arp_cache_lookup_table_regs
  import arp_cache_lookup_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             AXI_ACLK,
  input  logic             AXI_RESET,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [IP_W-1:0]  wr_ip,
  input  logic [MAC_W-1:0] wr_mac,
  input  logic             wr_vld,
  input  logic [IDX_W-1:0] scan_idx,
  output arp_entry_t       scan_entry,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [IP_W-1:0]  rd_ip,
  output logic [MAC_W-1:0] rd_mac,
  output logic             rd_vld
);
  logic [DEPTH-1:0] vld_q;
  logic [IP_W-1:0]  ip_q  [DEPTH];
  logic [MAC_W-1:0] mac_q [DEPTH];

  // Only valid bits are reset; stale IP/MAC contents are masked by vld.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET)  vld_q <= '0;
    else if (wr_en) vld_q[wr_addr] <= wr_vld;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) begin
      ip_q[wr_addr]  <= wr_ip;
      mac_q[wr_addr] <= wr_mac;
    end
  end

  assign scan_entry = '{vld: vld_q[scan_idx], ip: ip_q[scan_idx], mac: mac_q[scan_idx]};
  assign rd_ip  = ip_q[rd_addr];
  assign rd_mac = mac_q[rd_addr];
  assign rd_vld = vld_q[rd_addr];
endmodule

// File: rtl/arp_cache_lookup.sv
// Sequential ARP table search: resolves a next-hop IPv4 address to a destination MAC.
module arp_cache_lookup
  import arp_cache_lookup_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int ARP_DEPTH          = 32,
  parameter int ARP_IDX_W          = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  arp_cache_lookup_if.slave             lk,
  input  logic                          tbl_wr_en,
  input  logic [ARP_IDX_W-1:0]          tbl_wr_addr,
  input  logic [IP_W-1:0]               tbl_wr_ip,
  input  logic [MAC_W-1:0]              tbl_wr_mac,
  input  logic                          tbl_wr_vld,
  input  logic [ARP_IDX_W-1:0]          tbl_rd_addr,
  output logic [IP_W-1:0]               tbl_rd_ip,
  output logic [MAC_W-1:0]              tbl_rd_mac,
  output logic                          tbl_rd_vld,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] arp_lookup_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] arp_hit_count
);
  arp_state_e           state_q, state_d;
  logic [ARP_IDX_W-1:0] idx_q;
  logic [IP_W-1:0]      ip_q;
  arp_entry_t           scan;
  logic                 accept, match, last, clr;

  arp_cache_lookup_table_regs #(.DEPTH(ARP_DEPTH), .IDX_W(ARP_IDX_W)) u_tbl (
    .AXI_ACLK  (AXI_ACLK),
    .AXI_RESET (AXI_RESET),
    .wr_en     (tbl_wr_en),
    .wr_addr   (tbl_wr_addr),
    .wr_ip     (tbl_wr_ip),
    .wr_mac    (tbl_wr_mac),
    .wr_vld    (tbl_wr_vld),
    .scan_idx  (idx_q),
    .scan_entry(scan),
    .rd_addr   (tbl_rd_addr),
    .rd_ip     (tbl_rd_ip),
    .rd_mac    (tbl_rd_mac),
    .rd_vld    (tbl_rd_vld)
  );

  assign accept = (state_q == ST_IDLE) && lk.lookup_req;
  assign match  = (state_q == ST_SEARCH) && scan.vld && (scan.ip == ip_q);
  assign last   = (idx_q == ARP_IDX_W'(ARP_DEPTH - 1));
  assign clr    = (reset == C_S_AXI_DATA_WIDTH'(CNT_CLR));

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (lk.lookup_req)   state_d = ST_SEARCH;
      ST_SEARCH: if (match || last)   state_d = ST_DONE;
      ST_DONE:   if (lk.lookup_ack)   state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Result registers only move on accept or at the end of a scan, so they hold through DONE.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      idx_q       <= '0;
      ip_q        <= '0;
      lk.arp_hit  <= 1'b0;
      lk.dest_mac <= '0;
      lk.oq_reg   <= '0;
    end else if (accept) begin
      idx_q     <= '0;
      ip_q      <= lk.next_hop_ip;
      lk.oq_reg <= lk.oq_in;
    end else if (state_q == ST_SEARCH) begin
      if (match) begin
        lk.arp_hit  <= 1'b1;
        lk.dest_mac <= scan.mac;
      end else if (last) begin
        lk.arp_hit  <= 1'b0;
        lk.dest_mac <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Software clear takes priority over a same-cycle increment.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      arp_lookup_count <= '0;
      arp_hit_count    <= '0;
    end else if (clr) begin
      arp_lookup_count <= '0;
      arp_hit_count    <= '0;
    end else begin
      if (accept) arp_lookup_count <= arp_lookup_count + 1'b1;
      if (match)  arp_hit_count    <= arp_hit_count + 1'b1;
    end
  end

  assign lk.lookup_ready = (state_q == ST_IDLE);
  assign lk.lookup_valid = (state_q == ST_DONE);
endmodule

// File: tb/tb_arp_cache_lookup.sv
// Scoreboard bench for arp_cache_lookup: directed cases plus randomized table/lookup traffic.
module tb_arp_cache_lookup;
  localparam int DEPTH = 32;
  localparam int IDXW  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_vld = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_ip = '0;
  logic [47:0] wr_mac = '0;
  logic [31:0] rd_ip;
  logic [47:0] rd_mac;
  logic        rd_vld;
  logic [31:0] cnt_clr = '0;
  logic [31:0] lookup_cnt, hit_cnt;

  arp_cache_lookup_if lk();

  arp_cache_lookup #(.C_S_AXI_DATA_WIDTH(32), .ARP_DEPTH(DEPTH), .ARP_IDX_W(IDXW)) dut (
    .AXI_ACLK(clk), .AXI_RESET(rst), .lk(lk),
    .tbl_wr_en(wr_en), .tbl_wr_addr(wr_addr), .tbl_wr_ip(wr_ip), .tbl_wr_mac(wr_mac),
    .tbl_wr_vld(wr_vld), .tbl_rd_addr(rd_addr), .tbl_rd_ip(rd_ip), .tbl_rd_mac(rd_mac),
    .tbl_rd_vld(rd_vld), .reset(cnt_clr), .arp_lookup_count(lookup_cnt),
    .arp_hit_count(hit_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: table contents and counters as plain arrays.
  logic        m_vld [DEPTH];
  logic [31:0] m_ip  [DEPTH];
  logic [47:0] m_mac [DEPTH];
  logic        m_wr  [DEPTH];
  int          m_lookups = 0, m_hits = 0;

  typedef struct {
    logic        hit;
    logic [47:0] mac;
    logic [7:0]  oq;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  // First valid entry with the wanted IP wins; latency counts accept cycle to first valid cycle.
  function automatic void model_lookup(input logic [31:0] ip, output logic hit,
                                       output logic [47:0] mac, output int lat);
    hit = 1'b0; mac = '0; lat = DEPTH + 1;
    for (int i = 0; i < DEPTH; i++)
      if (!hit && m_vld[i] && m_ip[i] == ip) begin
        hit = 1'b1; mac = m_mac[i]; lat = i + 2;
      end
  endfunction

  // Monitor / consumer: compares each result, checks stability while held, then acks.
  int   ack_delay = 0, held = 0;
  bit   in_done = 0, ack_pend = 0;
  exp_t cur;
  logic        cap_hit;
  logic [47:0] cap_mac;
  logic [7:0]  cap_oq;

  always @(negedge clk) begin
    if (rst) begin
      in_done = 0; ack_pend = 0; lk.lookup_ack = 1'b0;
    end else if (ack_pend) begin
      lk.lookup_ack = 1'b0; ack_pend = 0; in_done = 0;
      chk("ready_after_ack", lk.lookup_ready, 1);
      chk("valid_after_ack", lk.lookup_valid, 0);
    end else if (lk.lookup_valid) begin
      if (!in_done) begin
        in_done = 1; held = 0;
        cap_hit = lk.arp_hit; cap_mac = lk.dest_mac; cap_oq = lk.oq_reg;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_result: got valid with empty scoreboard (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
          chk("arp_hit", lk.arp_hit, cur.hit);
          chk("dest_mac", lk.dest_mac, cur.mac);
          chk("oq_reg", lk.oq_reg, cur.oq);
          chk("latency", cyc - cur.acc + 1, cur.lat);
        end
      end else begin
        chk("hold_hit", lk.arp_hit, cap_hit);
        chk("hold_mac", lk.dest_mac, cap_mac);
        chk("hold_oq", lk.oq_reg, cap_oq);
      end
      held++;
      if (held > ack_delay) begin lk.lookup_ack = 1'b1; ack_pend = 1; end
    end
  end

  task automatic tbl_write(input int a, input logic [31:0] ip, input logic [47:0] mac,
                           input logic v);
    wr_en = 1'b1; wr_addr = 5'(a); wr_ip = ip; wr_mac = mac; wr_vld = v;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    m_vld[a] = v; m_ip[a] = ip; m_mac[a] = mac; m_wr[a] = 1'b1;
  endtask

  task automatic do_lookup(input logic [31:0] ip, input logic [7:0] oq, input bit push,
                           output int acc);
    exp_t e;
    int   t = 0;
    while (!lk.lookup_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      errors++; checks++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 100 cycles");
    end
    model_lookup(ip, e.hit, e.mac, e.lat);
    e.oq = oq;
    lk.lookup_req = 1'b1; lk.next_hop_ip = ip; lk.oq_in = oq;
    @(posedge clk); @(negedge clk);
    lk.lookup_req = 1'b0; lk.next_hop_ip = $urandom; lk.oq_in = 8'($urandom);
    acc = cyc; e.acc = acc;
    if (push) begin
      sb.push_back(e);
      m_lookups++;
      if (e.hit) m_hits++;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(sb.size() == 0 && lk.lookup_ready && !ack_pend) && t < 200) begin
      @(negedge clk); t++;
    end
    if (t >= 200) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no completion expected one within 200 cycles");
    end
  endtask

  task automatic chk_counts();
    chk("arp_lookup_count", lookup_cnt, m_lookups);
    chk("arp_hit_count", hit_cnt, m_hits);
  endtask

  task automatic chk_rd(input int a);
    rd_addr = 5'(a); #1;
    chk("tbl_rd_vld", rd_vld, m_vld[a]);
    if (m_wr[a]) begin
      chk("tbl_rd_ip", rd_ip, m_ip[a]);
      chk("tbl_rd_mac", rd_mac, m_mac[a]);
    end
  endtask

  initial begin
    int a, t;
    lk.lookup_req = 1'b0; lk.next_hop_ip = '0; lk.oq_in = '0; lk.lookup_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 0; m_ip[i] = '0; m_mac[i] = '0; m_wr[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ready", lk.lookup_ready, 1);
    chk("rst_valid", lk.lookup_valid, 0);
    chk("rst_hit", lk.arp_hit, 0);
    chk("rst_mac", lk.dest_mac, 0);
    chk("rst_oq", lk.oq_reg, 0);
    chk_counts();
    for (int i = 0; i < DEPTH; i++) chk_rd(i);

    // Empty table miss, worst-case latency
    do_lookup(32'h0A000009, 8'h01, 1, a); wait_idle(); chk_counts();

    // Single entry hit at idx 3
    tbl_write(3, 32'h0A000002, 48'h001122334455, 1'b1); chk_rd(3);
    do_lookup(32'h0A000002, 8'h04, 1, a); wait_idle(); chk_counts();

    // Duplicate IPs: lowest index wins
    tbl_write(5, 32'h0A000007, 48'h000000000005, 1'b1);
    tbl_write(9, 32'h0A000007, 48'h000000000009, 1'b1);
    do_lookup(32'h0A000007, 8'h10, 1, a); wait_idle(); chk_counts();

    // Long hold in DONE with a table write underneath
    ack_delay = 10;
    do_lookup(32'h0A000007, 8'h20, 1, a);
    t = 0;
    while (!lk.lookup_valid && t < 50) begin @(negedge clk); t++; end
    tbl_write(5, 32'h0A000007, 48'hAABBCCDDEEFF, 1'b1);
    wait_idle(); ack_delay = 0; chk_counts(); chk_rd(5);

    // Counter clear coincident with the hit edge
    do_lookup(32'h0A000002, 8'h02, 1, a);
    cnt_clr = 32'd1;
    repeat (4) @(posedge clk);
    @(negedge clk); cnt_clr = '0;
    m_lookups = 0; m_hits = 0;
    wait_idle(); chk_counts();

    // Non-magic clear value leaves counters alone
    cnt_clr = 32'd2;
    do_lookup(32'h0A000007, 8'h08, 1, a); wait_idle(); chk_counts();
    cnt_clr = '0;

    // Delete an already-scanned entry mid-search, then delete entry 3
    tbl_write(0, 32'h0A000032, 48'h0000000000F0, 1'b1);
    do_lookup(32'h0A000063, 8'h40, 1, a);
    repeat (20) @(negedge clk);
    tbl_write(0, 32'h0A000032, 48'h0000000000F0, 1'b0);
    wait_idle(); chk_rd(0);
    tbl_write(3, 32'h0A000002, 48'h001122334455, 1'b0);
    do_lookup(32'h0A000002, 8'h80, 1, a); wait_idle(); chk_counts();

    // Randomized table churn and lookups over a small IP pool
    for (int n = 0; n < 16; n++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        tbl_write($urandom_range(0, DEPTH - 1), 32'h0A000100 + 32'($urandom_range(0, 7)),
                  {16'($urandom), 32'($urandom)}, ($urandom_range(0, 3) != 0));
      ack_delay = $urandom_range(0, 3);
      do_lookup(32'h0A000100 + 32'($urandom_range(0, 7)), 8'(1 << $urandom_range(0, 7)), 1, a);
      wait_idle(); chk_counts();
      chk_rd($urandom_range(0, DEPTH - 1));
    end
    ack_delay = 0;

    // Hard reset mid-search abandons the lookup and invalidates the table
    do_lookup(32'h0A0000FE, 8'h01, 0, a);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    m_lookups = 0; m_hits = 0;
    @(negedge clk);
    chk("arst_ready", lk.lookup_ready, 1);
    chk("arst_valid", lk.lookup_valid, 0);
    chk_counts();
    for (int i = 0; i < DEPTH; i++) chk_rd(i);
    repeat (40) @(negedge clk);
    chk("arst_no_result", lk.lookup_valid, 0);

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
